// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encodings, command codes and HALT encoding for the fetch run controller.
package cpu_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_PAUSE = 2'b11;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
endpackage

// File: rtl/fetch_run_ctrl_sat_counter.sv
// sat_counter: synchronous up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [nbits-1:0] count
);
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
  end
endmodule

// File: rtl/fetch_run_ctrl.sv
// fetch_run_ctrl: RUN/STEP/PAUSE sequencer for fetch db_ena, HALT detection and pipeline drain.
// Optional watchdog enabled by defining CYCLE_LIMIT_EN.
module fetch_run_ctrl
  import cpu_pkg::*;
#(
  parameter int          CYCLE_W    = 32,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT,
  parameter int          DRAIN_CYC  = 4,
  parameter int          MAX_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_code,
  output logic               cmd_ready,
  input  logic [31:0]        instruction,
  output logic               db_ena,
  output logic               PC_end,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [2:0]         state
);
  state_t     r_state, w_next;
  logic [3:0] r_drain, w_drain_nx;
  logic       r_cmd_ready, r_db_ena, r_pc_end, r_busy, r_done;
  logic       w_acc, w_fetching, w_halt, w_lim;
  assign w_acc      = cmd_valid && r_cmd_ready;
  assign w_fetching = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_halt     = w_fetching && (instruction == HALT_WORD);
`ifdef CYCLE_LIMIT_EN
  logic r_timeout;
  assign w_lim = (r_state == ST_RUN) && (cycle_count == CYCLE_W'(MAX_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (reset) r_timeout <= 1'b0;
    else r_timeout <= r_timeout | w_lim;
  end
  assign timeout = r_timeout;
`else
  logic w_unused_max;
  assign w_unused_max = ^MAX_CYCLES;
  assign w_lim        = 1'b0;
  assign timeout      = 1'b0;
`endif
  // HALT and watchdog outrank any command seen in the same cycle
  always_comb begin
    w_next     = r_state;
    w_drain_nx = r_drain;
    if (w_halt || w_lim) begin
      w_next     = ST_DRAIN;
      w_drain_nx = 4'(DRAIN_CYC - 1);
    end else begin
      case (r_state)
        ST_IDLE:  w_next = (w_acc && cmd_code == CMD_RUN)  ? ST_RUN  :
                           (w_acc && cmd_code == CMD_STEP) ? ST_STEP : ST_IDLE;
        ST_RUN:   w_next = (w_acc && cmd_code == CMD_PAUSE) ? ST_IDLE : ST_RUN;
        ST_STEP:  w_next = ST_IDLE;
        ST_DRAIN: begin
          w_next     = (r_drain == 4'd0) ? ST_DONE : ST_DRAIN;
          w_drain_nx = (r_drain == 4'd0) ? r_drain : r_drain - 4'd1;
        end
        ST_DONE:  w_next = ST_DONE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_drain     <= 4'd0;
      r_cmd_ready <= 1'b1;
      r_db_ena    <= 1'b0;
      r_pc_end    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_drain     <= w_drain_nx;
      r_cmd_ready <= (w_next == ST_IDLE) || (w_next == ST_RUN);
      r_db_ena    <= (w_next == ST_RUN) || (w_next == ST_STEP) || (w_next == ST_DRAIN);
      r_busy      <= (w_next == ST_RUN) || (w_next == ST_STEP) || (w_next == ST_DRAIN);
      r_pc_end    <= r_pc_end | w_halt | w_lim;
      r_done      <= r_done | (w_next == ST_DONE);
    end
  end
  sat_counter #(.nbits(CYCLE_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_fetching),
    .count (cycle_count)
  );
  assign cmd_ready = r_cmd_ready;
  assign db_ena    = r_db_ena;
  assign PC_end    = r_pc_end;
  assign busy      = r_busy;
  assign done      = r_done;
  assign state     = r_state;
endmodule
